// File: rtl/frame_pixel_unpacker.sv
// frame_pixel_unpacker: pops FWFT FIFO words and issues one pixel per pix_req, keeping frame alignment.
// Optional FPU_PIX_COORD_EN adds registered pix_x/pix_y outputs aligned with pix_vld.
module frame_pixel_unpacker #(
    parameter int              WORD_W   = 32,
    parameter int              PIX_W    = 16,
    parameter int              H_ACTIVE = 640,
    parameter int              V_ACTIVE = 480,
    parameter logic [PIX_W-1:0] FILL_PIX = '0
) (
    input  logic              rd_clk,
    input  logic              rd_rst,
    input  logic [WORD_W-1:0] fifo_data,
    input  logic              fifo_vld,
    output logic              fifo_en,
    input  logic              frame_start,
    input  logic              pix_req,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_vld,
    output logic              underflow,
    output logic              resync,
    output logic              frame_done
`ifdef FPU_PIX_COORD_EN
    ,
    output logic [$clog2(H_ACTIVE)-1:0] pix_x,
    output logic [$clog2(V_ACTIVE)-1:0] pix_y
`endif
);
    localparam int PPW  = WORD_W / PIX_W;
    localparam int NPIX = H_ACTIVE * V_ACTIVE;
    localparam int WPF  = NPIX / PPW;
    localparam int SW   = PPW > 1 ? $clog2(PPW) : 1;
    localparam int PW   = NPIX > 1 ? $clog2(NPIX) : 1;
    localparam int CW   = $clog2(WPF + 1);
    localparam logic [SW-1:0] SEL_LAST = SW'(PPW - 1);
    localparam logic [PW-1:0] PIX_LAST = PW'(NPIX - 1);
    localparam logic [CW-1:0] WPF_C    = CW'(WPF);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] wbuf_q, wbuf_d;
    logic              buf_v_q, buf_v_d;
    logic [SW-1:0]     sel_q, sel_d;
    logic [PW-1:0]     pcnt_q, pcnt_d;
    logic [CW-1:0]     wcnt_q, wcnt_d;
    logic [CW-1:0]     debt_q, debt_d;
    logic              start_pend_q, start_pend_d;
    logic [PIX_W-1:0]  pix_data_q, pix_data_d;
    logic              pix_vld_q, pix_vld_d;
    logic              underflow_q, underflow_d;
    logic              resync_q, resync_d;
    logic              frame_done_q, frame_done_d;
    logic              can_pop, init, active;

    always_comb begin
        state_d      = state_q;
        wbuf_d       = wbuf_q;
        buf_v_d      = buf_v_q;
        sel_d        = sel_q;
        pcnt_d       = pcnt_q;
        wcnt_d       = wcnt_q;
        debt_d       = debt_q;
        start_pend_d = start_pend_q;
        underflow_d  = underflow_q;
        pix_data_d   = FILL_PIX;
        pix_vld_d    = pix_req;
        resync_d     = 1'b0;
        frame_done_d = 1'b0;
        fifo_en      = 1'b0;
        init         = 1'b0;
        active       = 1'b0;
        can_pop      = fifo_vld && (wcnt_q != WPF_C);
        case (state_q)
            IDLE: init = frame_start;
            RUN: begin
                if (frame_start && !(pix_req && pcnt_q == PIX_LAST)) begin
                    resync_d     = 1'b1;
                    start_pend_d = 1'b1;
                    buf_v_d      = 1'b0;
                    state_d      = FLUSH;
                end else begin
                    // Late words for slots already filled with FILL_PIX are discarded first
                    if (debt_q != '0 && can_pop) begin
                        fifo_en = 1'b1;
                        debt_d  = debt_q - 1'b1;
                    end
                    if (pix_req) begin
                        active = 1'b1;
                        if (buf_v_q) begin
                            pix_data_d = wbuf_q[sel_q*PIX_W +: PIX_W];
                            buf_v_d    = (sel_q != SEL_LAST);
                        end else if (sel_q == '0 && can_pop && debt_q == '0) begin
                            fifo_en    = 1'b1;
                            wbuf_d     = fifo_data;
                            buf_v_d    = PPW > 1;
                            pix_data_d = fifo_data[PIX_W-1:0];
                        end else begin
                            underflow_d = 1'b1;
                            debt_d      = (sel_q == '0) ? debt_d + 1'b1 : debt_d;
                        end
                        sel_d  = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
                        pcnt_d = (pcnt_q == PIX_LAST) ? pcnt_q : pcnt_q + 1'b1;
                    end else if (!buf_v_q && sel_q == '0 && debt_q == '0 && can_pop) begin
                        fifo_en = 1'b1;
                        wbuf_d  = fifo_data;
                        buf_v_d = 1'b1;
                    end
                    wcnt_d = wcnt_q + CW'(fifo_en);
                    if (pix_req && pcnt_q == PIX_LAST) begin
                        frame_done_d = 1'b1;
                        start_pend_d = frame_start;
                        init         = frame_start && (wcnt_d == WPF_C);
                        state_d      = (wcnt_d == WPF_C) ? IDLE : FLUSH;
                    end
                end
            end
            default: begin
                fifo_en      = can_pop;
                wcnt_d       = wcnt_q + CW'(fifo_en);
                start_pend_d = start_pend_q || frame_start;
                init         = (wcnt_d == WPF_C) && start_pend_d;
                state_d      = (wcnt_d == WPF_C) ? IDLE : FLUSH;
            end
        endcase
        if (init) begin
            state_d      = RUN;
            pcnt_d       = '0;
            wcnt_d       = '0;
            debt_d       = '0;
            sel_d        = '0;
            buf_v_d      = 1'b0;
            underflow_d  = 1'b0;
            start_pend_d = 1'b0;
        end
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state_q      <= IDLE;
            wbuf_q       <= '0;
            buf_v_q      <= 1'b0;
            sel_q        <= '0;
            pcnt_q       <= '0;
            wcnt_q       <= '0;
            debt_q       <= '0;
            start_pend_q <= 1'b0;
            pix_data_q   <= '0;
            pix_vld_q    <= 1'b0;
            underflow_q  <= 1'b0;
            resync_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wbuf_q       <= wbuf_d;
            buf_v_q      <= buf_v_d;
            sel_q        <= sel_d;
            pcnt_q       <= pcnt_d;
            wcnt_q       <= wcnt_d;
            debt_q       <= debt_d;
            start_pend_q <= start_pend_d;
            pix_data_q   <= pix_data_d;
            pix_vld_q    <= pix_vld_d;
            underflow_q  <= underflow_d;
            resync_q     <= resync_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign pix_data   = pix_data_q;
    assign pix_vld    = pix_vld_q;
    assign underflow  = underflow_q;
    assign resync     = resync_q;
    assign frame_done = frame_done_q;

`ifdef FPU_PIX_COORD_EN
    localparam int XW = $clog2(H_ACTIVE);
    localparam int YW = $clog2(V_ACTIVE);
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);

    logic [XW-1:0] xc_q, xc_d, pix_x_q, pix_x_d;
    logic [YW-1:0] yc_q, yc_d, pix_y_q, pix_y_d;

    // x/y shadow pcnt so no divider is needed
    always_comb begin
        xc_d    = xc_q;
        yc_d    = yc_q;
        pix_x_d = '0;
        pix_y_d = '0;
        if (active) begin
            pix_x_d = xc_q;
            pix_y_d = yc_q;
            xc_d    = (xc_q == X_LAST) ? '0 : xc_q + 1'b1;
            yc_d    = (xc_q == X_LAST) ? yc_q + 1'b1 : yc_q;
        end
        if (init) begin
            xc_d = '0;
            yc_d = '0;
        end
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            xc_q    <= '0;
            yc_q    <= '0;
            pix_x_q <= '0;
            pix_y_q <= '0;
        end else begin
            xc_q    <= xc_d;
            yc_q    <= yc_d;
            pix_x_q <= pix_x_d;
            pix_y_q <= pix_y_d;
        end
    end

    assign pix_x = pix_x_q;
    assign pix_y = pix_y_q;
`endif
endmodule

// File: tb/tb_frame_pixel_unpacker.sv
// tb_frame_pixel_unpacker: scoreboard bench for frame_pixel_unpacker with H=4, V=2, PPW=2, FILL=F00F.
// Define FPU_PIX_COORD_EN to also check pix_x/pix_y.
`timescale 1ns/1ps
module tb_frame_pixel_unpacker;
    localparam logic [15:0] FILL = 16'hF00F;

    typedef struct {
        logic [15:0] pix;
        logic        fd;
        int          idx;
    } exp_t;

    logic        rd_clk = 1'b0;
    logic        rd_rst = 1'b1;
    logic [31:0] fifo_data = '0;
    logic        fifo_vld = 1'b0;
    logic        fifo_en;
    logic        frame_start = 1'b0;
    logic        pix_req = 1'b0;
    logic [15:0] pix_data;
    logic        pix_vld, underflow, resync, frame_done;
`ifdef FPU_PIX_COORD_EN
    logic [1:0]  pix_x;
    logic [0:0]  pix_y;
    int          ex, ey;
`endif

    exp_t        exp_q[$];
    exp_t        me;
    logic [31:0] fifo_q[$];
    int          checks = 0;
    int          failures = 0;
    int          pops = 0;
    logic        req_s = 1'b0;
    logic        mon_en = 1'b0;
    logic        en_s;

    frame_pixel_unpacker #(
        .WORD_W(32), .PIX_W(16), .H_ACTIVE(4), .V_ACTIVE(2), .FILL_PIX(16'hF00F)
    ) dut (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .fifo_data(fifo_data), .fifo_vld(fifo_vld),
        .fifo_en(fifo_en), .frame_start(frame_start), .pix_req(pix_req), .pix_data(pix_data),
        .pix_vld(pix_vld), .underflow(underflow), .resync(resync), .frame_done(frame_done)
`ifdef FPU_PIX_COORD_EN
        , .pix_x(pix_x), .pix_y(pix_y)
`endif
    );

    always #5 rd_clk = ~rd_clk;

    always @(posedge rd_clk) req_s <= pix_req;

    // Scoreboard: every request must produce exactly one pixel one cycle later
    always @(negedge rd_clk) begin
        if (mon_en) begin
            checks++;
            if (pix_vld !== req_s) begin
                failures++;
                $display("FAIL pix_vld got %b exp %b at %0t", pix_vld, req_s, $time);
            end
            if (pix_vld === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL scoreboard got pixel %h with nothing expected", pix_data);
                end else begin
                    me = exp_q.pop_front();
                    if (pix_data !== me.pix || frame_done !== me.fd) begin
                        failures++;
                        $display("FAIL pixel idx=%0d got data=%h fd=%b exp data=%h fd=%b",
                                 me.idx, pix_data, frame_done, me.pix, me.fd);
                    end
`ifdef FPU_PIX_COORD_EN
                    ex = me.idx < 0 ? 0 : me.idx % 4;
                    ey = me.idx < 0 ? 0 : me.idx / 4;
                    checks++;
                    if (pix_x !== 2'(ex) || pix_y !== 1'(ey)) begin
                        failures++;
                        $display("FAIL coord idx=%0d got (%0d,%0d) exp (%0d,%0d)",
                                 me.idx, pix_x, pix_y, ex, ey);
                    end
`endif
                end
            end else begin
                checks++;
                if (frame_done !== 1'b0) begin
                    failures++;
                    $display("FAIL frame_done got %b without pixel exp 0", frame_done);
                end
            end
        end
    end

    task automatic refresh();
        fifo_vld  = fifo_q.size() != 0;
        fifo_data = fifo_vld ? fifo_q[0] : 32'h0;
    endtask

    task automatic push_word(input logic [31:0] w);
        fifo_q.push_back(w);
        refresh();
    endtask

    task automatic tick();
        @(negedge rd_clk);
        en_s = fifo_en && fifo_vld;
        @(posedge rd_clk);
        if (en_s) begin
            void'(fifo_q.pop_front());
            pops++;
        end
        #1;
        refresh();
    endtask

    task automatic drive(input logic req, input logic fs, input logic [15:0] pix,
                         input logic fd, input int idx);
        exp_t e;
        pix_req     = req;
        frame_start = fs;
        if (req) begin
            e.pix = pix;
            e.fd  = fd;
            e.idx = idx;
            exp_q.push_back(e);
        end
        tick();
        pix_req     = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic req_frame(input logic [31:0] w [4], input logic fs_last);
        logic [31:0] wd;
        for (int k = 0; k < 8; k++) begin
            wd = w[k/2];
            drive(1'b1, fs_last && k == 7, wd[(k%2)*16 +: 16], k == 7, k);
        end
    endtask

    task automatic test_reset();
        push_word(32'h12345678);
        repeat (3) @(posedge rd_clk);
        #1;
        checks++;
        if ({fifo_en, pix_vld, underflow, resync, frame_done, pix_data} !== 21'h0) begin
            failures++;
            $display("FAIL reset_outputs got %h exp 0",
                     {fifo_en, pix_vld, underflow, resync, frame_done, pix_data});
        end
        rd_rst = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, FILL, 1'b0, -1);
            checks++;
            if (fifo_en !== 1'b0) begin
                failures++;
                $display("FAIL idle_fifo_en got %b exp 0", fifo_en);
            end
        end
        checks++;
        if (underflow !== 1'b0 || pops != 0) begin
            failures++;
            $display("FAIL idle_flags underflow=%b pops=%0d exp 0/0", underflow, pops);
        end
        fifo_q.delete();
        refresh();
    endtask

    task automatic test_frame();
        logic [31:0] w [4];
        w = '{32'hBBBBAAAA, 32'hDDDDCCCC, 32'h22221111, 32'h44443333};
        pops = 0;
        foreach (w[i]) push_word(w[i]);
        drive(1'b0, 1'b1, FILL, 1'b0, -1);
        req_frame(w, 1'b0);
        checks++;
        if (pops != 4 || underflow !== 1'b0) begin
            failures++;
            $display("FAIL frame_pops got pops=%0d uf=%b exp 4/0", pops, underflow);
        end
        push_word(32'hDEADBEEF);
        #1;
        checks++;
        if (fifo_en !== 1'b0) begin
            failures++;
            $display("FAIL frame_idle_en got %b exp 0", fifo_en);
        end
        drive(1'b1, 1'b0, FILL, 1'b0, -1);
        fifo_q.delete();
        refresh();
    endtask

    task automatic test_underflow();
        pops = 0;
        push_word(32'hBBBBAAAA);
        drive(1'b0, 1'b1, FILL, 1'b0, -1);
        drive(1'b1, 1'b0, 16'hAAAA, 1'b0, 0);
        drive(1'b1, 1'b0, 16'hBBBB, 1'b0, 1);
        drive(1'b1, 1'b0, FILL, 1'b0, 2);
        drive(1'b1, 1'b0, FILL, 1'b0, 3);
        checks++;
        if (underflow !== 1'b1) begin
            failures++;
            $display("FAIL underflow_set got %b exp 1", underflow);
        end
        push_word(32'hDDDDCCCC);
        push_word(32'h22221111);
        push_word(32'h44443333);
        drive(1'b0, 1'b0, FILL, 1'b0, -1);
        checks++;
        if (pops != 2) begin
            failures++;
            $display("FAIL late_discard got pops=%0d exp 2", pops);
        end
        drive(1'b1, 1'b0, 16'h1111, 1'b0, 4);
        drive(1'b1, 1'b0, 16'h2222, 1'b0, 5);
        drive(1'b1, 1'b0, 16'h3333, 1'b0, 6);
        drive(1'b1, 1'b0, 16'h4444, 1'b1, 7);
        checks++;
        if (pops != 4 || underflow !== 1'b1) begin
            failures++;
            $display("FAIL underflow_end got pops=%0d uf=%b exp 4/1", pops, underflow);
        end
    endtask

    task automatic test_resync();
        logic [31:0] nw [4];
        nw = '{32'h66665555, 32'h88887777, 32'hAAAA9999, 32'hCCCCBBBB};
        pops = 0;
        push_word(32'hBBBBAAAA);
        push_word(32'hDDDDCCCC);
        push_word(32'h22221111);
        push_word(32'h44443333);
        foreach (nw[i]) push_word(nw[i]);
        drive(1'b0, 1'b1, FILL, 1'b0, -1);
        checks++;
        if (underflow !== 1'b0) begin
            failures++;
            $display("FAIL underflow_clear got %b exp 0", underflow);
        end
        drive(1'b1, 1'b0, 16'hAAAA, 1'b0, 0);
        drive(1'b1, 1'b0, 16'hBBBB, 1'b0, 1);
        drive(1'b1, 1'b0, 16'hCCCC, 1'b0, 2);
        drive(1'b0, 1'b1, FILL, 1'b0, -1);
        checks++;
        if (resync !== 1'b1) begin
            failures++;
            $display("FAIL resync_pulse got %b exp 1", resync);
        end
        drive(1'b0, 1'b0, FILL, 1'b0, -1);
        checks++;
        if (resync !== 1'b0) begin
            failures++;
            $display("FAIL resync_width got %b exp 0", resync);
        end
        repeat (3) drive(1'b0, 1'b0, FILL, 1'b0, -1);
        checks++;
        if (pops != 5) begin
            failures++;
            $display("FAIL flush_pops got %0d exp 5", pops);
        end
        req_frame(nw, 1'b0);
        checks++;
        if (pops != 8 || underflow !== 1'b0) begin
            failures++;
            $display("FAIL resync_frame got pops=%0d uf=%b exp 8/0", pops, underflow);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a [4];
        logic [31:0] b [4];
        a = '{32'h0B0A0A0A, 32'h0D0C0C0C, 32'h12341111, 32'h56785555};
        b = '{32'hFACEBEEF, 32'hC0DECAFE, 32'h0F0F7E7E, 32'h9ABC1357};
        pops = 0;
        foreach (a[i]) push_word(a[i]);
        foreach (b[i]) push_word(b[i]);
        drive(1'b0, 1'b1, FILL, 1'b0, -1);
        req_frame(a, 1'b1);
        checks++;
        if (resync !== 1'b0 || pops != 4) begin
            failures++;
            $display("FAIL b2b_boundary got resync=%b pops=%0d exp 0/4", resync, pops);
        end
        req_frame(b, 1'b0);
        checks++;
        if (pops != 8 || underflow !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second got pops=%0d uf=%b exp 8/0", pops, underflow);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_frame();
        test_underflow();
        test_resync();
        test_back_to_back();
        repeat (2) tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d left exp 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
